// File: rtl/mem_rr_arbiter_if.sv
// Bus bundle for mem_rr_arbiter: per-master request/response lanes, the shared slave port and status.
// The slave modport is the arbiter's view; the master modport is the surrounding masters/memory.
interface mem_rr_arbiter_if #(
    parameter int NR_PORTS        = 3,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4
);
    localparam int IDW = $clog2(NR_PORTS);
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW  = DATA_WIDTH / 8;

    logic [NR_PORTS-1:0]                 data_req_i;
    logic [NR_PORTS-1:0][63:0]           address_i;
    logic [NR_PORTS-1:0][DATA_WIDTH-1:0] data_wdata_i;
    logic [NR_PORTS-1:0]                 data_we_i;
    logic [NR_PORTS-1:0][BW-1:0]         data_be_i;
    logic [NR_PORTS-1:0][1:0]            data_size_i;
    logic [NR_PORTS-1:0]                 data_gnt_o;
    logic [NR_PORTS-1:0]                 data_rvalid_o;
    logic [NR_PORTS-1:0][DATA_WIDTH-1:0] data_rdata_o;

    logic                  data_req_o;
    logic [63:0]           address_o;
    logic [DATA_WIDTH-1:0] data_wdata_o;
    logic                  data_we_o;
    logic [BW-1:0]         data_be_o;
    logic [1:0]            data_size_o;
    logic [IDW-1:0]        id_o;
    logic                  data_gnt_i;
    logic                  data_rvalid_i;
    logic [DATA_WIDTH-1:0] data_rdata_i;

    logic [CW-1:0]         outstanding_o;
    logic                  err_o;
    logic [31:0]           stall_cnt_o;

    modport slave (
        input  data_req_i, address_i, data_wdata_i, data_we_i, data_be_i, data_size_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o,
        output data_req_o, address_o, data_wdata_o, data_we_o, data_be_o, data_size_o, id_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i,
        output outstanding_o, err_o, stall_cnt_o
    );

    modport master (
        output data_req_i, address_i, data_wdata_i, data_we_i, data_be_i, data_size_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o,
        input  data_req_o, address_o, data_wdata_o, data_we_o, data_be_o, data_size_o, id_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i,
        input  outstanding_o, err_o, stall_cnt_o
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one in-order memory port among NR_PORTS masters, with an ID FIFO for response routing.
// Optional slave stall counter enabled by defining MEM_ARB_STALL_CNT_EN.
module mem_rr_arbiter #(
    parameter int NR_PORTS        = 3,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    mem_rr_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NR_PORTS);
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0]  FULL_CNT  = CW'(MAX_OUTSTANDING);
    localparam logic [IDW-1:0] LAST_PORT = IDW'(NR_PORTS - 1);
    localparam logic [PW-1:0]  LAST_SLOT = PW'(MAX_OUTSTANDING - 1);

    logic [IDW-1:0] r_rr_ptr;
    logic           r_lock;
    logic [IDW-1:0] r_locked_id;
    logic [IDW-1:0] r_fifo [MAX_OUTSTANDING];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_err;

    logic [IDW-1:0] w_scan_sel;
    logic [IDW-1:0] w_sel;
    logic [IDW-1:0] w_head;
    logic           w_lock_ok;
    logic           w_lock_err;
    logic           w_fifo_full;
    logic           w_fifo_empty;
    logic           w_req;
    logic           w_accept;
    logic           w_pop;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(32'(base)) + k;
        if (s >= NR_PORTS) begin
            s = s - NR_PORTS;
        end else begin
            s = s;
        end
        return IDW'(s);
    endfunction

    // Round-robin scan from r_rr_ptr; descending loop so the nearest requester wins.
    always_comb begin
        w_scan_sel = r_rr_ptr;
        for (int k = NR_PORTS - 1; k >= 0; k--) begin
            w_scan_sel = bus.data_req_i[wrap_add(r_rr_ptr, k)] ? wrap_add(r_rr_ptr, k) : w_scan_sel;
        end
    end

    // A held lock pins the selection; a locked master that drops req falls back to the scan.
    assign w_lock_ok    = r_lock && bus.data_req_i[r_locked_id];
    assign w_lock_err   = r_lock && !bus.data_req_i[r_locked_id];
    assign w_sel        = w_lock_ok ? r_locked_id : w_scan_sel;
    assign w_fifo_full  = (r_count == FULL_CNT);
    assign w_fifo_empty = (r_count == {CW{1'b0}});
    assign w_req        = rst_ni && (|bus.data_req_i) && !w_fifo_full;
    assign w_accept     = w_req && bus.data_gnt_i;
    assign w_pop        = bus.data_rvalid_i && !w_fifo_empty;
    assign w_head       = r_fifo[r_rd_ptr];

    // Slave-side payload mux and master grant.
    always_comb begin
        bus.data_req_o   = 1'b0;
        bus.address_o    = 64'd0;
        bus.data_wdata_o = '0;
        bus.data_we_o    = 1'b0;
        bus.data_be_o    = '0;
        bus.data_size_o  = 2'd0;
        bus.id_o         = '0;
        bus.data_gnt_o   = '0;
        if (w_req) begin
            bus.data_req_o        = 1'b1;
            bus.address_o         = bus.address_i[w_sel];
            bus.data_wdata_o      = bus.data_wdata_i[w_sel];
            bus.data_we_o         = bus.data_we_i[w_sel];
            bus.data_be_o         = bus.data_be_i[w_sel];
            bus.data_size_o       = bus.data_size_i[w_sel];
            bus.id_o              = w_sel;
            bus.data_gnt_o[w_sel] = bus.data_gnt_i;
        end else begin
            bus.data_req_o = 1'b0;
        end
    end

    // Route the in-order response to the master at the FIFO head.
    always_comb begin
        bus.data_rvalid_o = '0;
        bus.data_rdata_o  = '0;
        if (w_pop) begin
            bus.data_rvalid_o[w_head] = 1'b1;
            bus.data_rdata_o[w_head]  = bus.data_rdata_i;
        end else begin
            bus.data_rvalid_o = '0;
        end
    end

    // Round-robin pointer and lock tracking; a stalled request locks, anything else unlocks.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr    <= '0;
            r_lock      <= 1'b0;
            r_locked_id <= '0;
        end else begin
            if (w_accept) begin
                r_rr_ptr <= (w_sel == LAST_PORT) ? {IDW{1'b0}} : w_sel + IDW'(1);
            end else begin
                r_rr_ptr <= r_rr_ptr;
            end
            if (w_req && !bus.data_gnt_i) begin
                r_lock      <= 1'b1;
                r_locked_id <= w_sel;
            end else begin
                r_lock      <= 1'b0;
                r_locked_id <= r_locked_id;
            end
        end
    end

    // ID FIFO; full blocks requests even on a same-cycle pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_fifo[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_fifo[r_wr_ptr] <= w_sel;
                r_wr_ptr         <= (r_wr_ptr == LAST_SLOT) ? {PW{1'b0}} : r_wr_ptr + PW'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_SLOT) ? {PW{1'b0}} : r_rd_ptr + PW'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky protocol error: orphan response or locked master withdrawing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (w_lock_err || (bus.data_rvalid_i && w_fifo_empty)) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign bus.outstanding_o = r_count;
    assign bus.err_o         = r_err;

`ifdef MEM_ARB_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of cycles the slave holds off a pending request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= 32'd0;
        end else if (w_req && !bus.data_gnt_i && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign bus.stall_cnt_o = r_stall_cnt;
`else
    assign bus.stall_cnt_o = 32'd0;
`endif

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Shares one in-order memory slave port between NR_PORTS master ports using a req/gnt/rvalid handshake.
- Uses round-robin arbitration and allows up to MAX_OUTSTANDING accepted-but-unanswered transactions.
- An internal ID FIFO routes each in-order response back to the master that issued it.
- Sits between the core-side load/store/fetch requesters and the shared memory or interconnect port. It replaces single-outstanding fixed-priority sharing.

Parameters:
- NR_PORTS, 3, number of master ports (>=2).
- DATA_WIDTH, 64, data bus width (multiple of 8).
- MAX_OUTSTANDING, 4, depth of the response-routing ID FIFO (>=1).
- IDW (localparam), $clog2(NR_PORTS), port index width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- data_req_i  in  NR_PORTS  per-master request
- address_i  in  NR_PORTS x 64  per-master address
- data_wdata_i  in  NR_PORTS x DATA_WIDTH  per-master write data
- data_we_i  in  NR_PORTS  per-master write enable
- data_be_i  in  NR_PORTS x DATA_WIDTH/8  per-master byte enables
- data_size_i  in  NR_PORTS x 2  per-master access size
- data_gnt_o  out  NR_PORTS  per-master grant
- data_rvalid_o  out  NR_PORTS  per-master response valid
- data_rdata_o  out  NR_PORTS x DATA_WIDTH  per-master read data
- data_req_o  out  1  slave request
- address_o  out  64  slave address
- data_wdata_o  out  DATA_WIDTH  slave write data
- data_we_o  out  1  slave write enable
- data_be_o  out  DATA_WIDTH/8  slave byte enables
- data_size_o  out  2  slave access size
- id_o  out  IDW  index of the master currently driving the slave port
- data_gnt_i  in  1  slave grant
- data_rvalid_i  in  1  slave response valid (in order)
- data_rdata_i  in  DATA_WIDTH  slave read data
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current ID FIFO occupancy
- err_o  out  1  sticky protocol error
- stall_cnt_o  out  32  slave stall cycle count (see Optional Feature)

Behaviour:
- Reset is asynchronous on rst_ni low. It clears: RR pointer to 0, lock flag, FIFO pointers and count, err_o, stall counter. All outputs are 0 during reset and while idle.
- Handshake rules:
  - A transfer is accepted when data_req_o && data_gnt_i.
  - Masters hold req and payload stable until their gnt.
  - The slave returns exactly one rvalid per accepted transfer, in acceptance order.
- Arbitration:
  - The selected port sel is the first i with data_req_i[i]=1, scanning from rr_ptr upward modulo NR_PORTS.
  - On acceptance, rr_ptr <= (sel+1) mod NR_PORTS.
  - With no request pending, rr_ptr holds.
- Lock:
  - If data_req_o=1 and data_gnt_i=0, lock_q sets and locked_id_q <= sel.
  - While locked, sel = locked_id_q regardless of other requests. The slave payload therefore never switches mid-handshake.
  - Lock clears on acceptance.
  - If the locked master drops req (protocol violation), set err_o and clear the lock.
- Request path (combinational, zero latency):
  - data_req_o = |data_req_i && !fifo_full.
  - Payload, id_o = data of sel; all zero when data_req_o=0.
  - data_gnt_o[sel] = data_gnt_i && data_req_o; all other bits 0.
- ID FIFO:
  - Accepted sel is pushed on acceptance.
  - Head is popped on data_rvalid_i.
  - Full blocks new requests even if a pop occurs in the same cycle (no bypass). This gives a one-cycle bubble at full and is intentional.
  - Simultaneous push and pop when not full: count unchanged, both pointers advance.
  - Pointers wrap modulo MAX_OUTSTANDING.
  - outstanding_o = count.
- Response path (combinational):
  - On data_rvalid_i with FIFO non-empty: data_rvalid_o[head]=1 and data_rdata_o[head]=data_rdata_i.
  - All other rdata lanes are 0.
  - data_rvalid_i with FIFO empty: ignored (no rvalid_o) and err_o set.
- err_o is sticky until reset.
- Latency:
  - Request to slave: 0 cycles.
  - Response to master: 0 cycles after data_rvalid_i.
  - Response may arrive the cycle after acceptance at earliest; same-cycle accept+rvalid for the same transfer is not supported.

Optional Feature:
- Macro: MEM_ARB_STALL_CNT_EN.
- Defined: 32-bit counter increments each cycle with data_req_o=1 && data_gnt_i=0. It saturates at 0xFFFFFFFF, resets to 0, and drives stall_cnt_o.
- Undefined: no counter logic; stall_cnt_o tied to 0.

Test Plan:
- Ports 0,1,2 request continuously, data_gnt_i=1, rvalid one cycle after each grant -> grants in order 0,1,2,0,1,2. Each master receives rvalid with its own rdata (e.g. 0xA0,0xA1,0xA2).
- Port 1 requests with data_gnt_i=0 for 3 cycles while port 0 raises req in cycle 2 -> id_o stays 1 and address stays port 1's until gnt. Then rr_ptr=2, and port 0 is served next.
- MAX_OUTSTANDING=4, gnt always 1, no rvalid -> 4 grants, outstanding_o=4, data_req_o=0. One rvalid -> outstanding_o=3 and requests resume the following cycle.
- Issue port 2 then port 0, responses 0x11, 0x22 -> data_rvalid_o[2] with 0x11, then data_rvalid_o[0] with 0x22. The FIFO head wraps correctly over 10 rounds.
- data_rvalid_i pulsed with empty FIFO -> no data_rvalid_o, err_o=1 and held. Assert rst_ni=0 mid-transfer with 2 outstanding -> outstanding_o=0, err_o=0, all outputs 0.
- With MEM_ARB_STALL_CNT_EN: 5 cycles of req with no gnt -> stall_cnt_o=5. Without the macro -> stall_cnt_o=0.
